// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: register/word typedefs, bypass bus
// bundle and the per-source resolution rule shared by both read ports.
package operand_fetch_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0]      RegAddr;
    typedef logic [XLEN-1:0] Word;

    localparam RegAddr ZERO_REG = 5'd0;

    typedef struct packed {
        logic   valid;
        RegAddr rdAddr;
        logic   dataReady;
        Word    data;
    } BypassPort;

    typedef struct packed {
        logic ready;
        Word  value;
    } Operand;

    // Youngest producer wins (EX, then MEM, then WB); the register file is only
    // trusted when no writer of this register is still in flight.
    function automatic Operand resolve_operand(
        input logic      used,
        input RegAddr    addr,
        input Word       rf_data,
        input logic      busy,
        input BypassPort ex,
        input BypassPort mem,
        input BypassPort wb
    );
        Operand op;
        op.ready = 1'b1;
        op.value = '0;
        if (used && addr != ZERO_REG) begin
            if (ex.valid && ex.rdAddr == addr) begin
                op.ready = ex.dataReady;
                op.value = ex.data;
            end else if (mem.valid && mem.rdAddr == addr) begin
                op.ready = mem.dataReady;
                op.value = mem.data;
            end else if (wb.valid && wb.rdAddr == addr) begin
                op.value = wb.data;
            end else begin
                op.ready = !busy;
                op.value = rf_data;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register count of issued-but-not-retired writers, with busy queries for
// the two sources and a saturation check for the incoming destination.
module scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  RegAddr inc_addr,
    input  logic   dec,
    input  RegAddr dec_addr,
    input  RegAddr rs1_addr,
    input  RegAddr rs2_addr,
    input  RegAddr rd_addr,
    input  logic   rd_pending,
    output logic   rs1_busy,
    output logic   rs2_busy,
    output logic   rd_full
);

    localparam logic [CNT_W:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count [NREG];
    logic [CNT_W:0]   rd_total;

    assign rs1_busy = count[rs1_addr] != '0;
    assign rs2_busy = count[rs2_addr] != '0;

    // rd_pending covers a held writer of the same rd that will increment before this one does.
    assign rd_total = {1'b0, count[rd_addr]} + {{CNT_W{1'b0}}, rd_pending};
    assign rd_full  = rd_total >= CNT_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc && inc_addr == RegAddr'(i) && !(dec && dec_addr == RegAddr'(i))) begin
                    count[i] <= count[i] + ONE;
                end else if (dec && dec_addr == RegAddr'(i) && !(inc && inc_addr == RegAddr'(i))) begin
                    count[i] <= count[i] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && dec && !(inc && inc_addr == dec_addr)) begin
            assert (count[dec_addr] != '0)
                else $error("scoreboard: retire of x%0d with no writer in flight", dec_addr);
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read, EX/MEM/WB bypass, RAW stall via the
// scoreboard, and a single-entry valid/ready output register toward execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      inRs1Addr,
    input  logic [4:0]      inRs2Addr,
    input  logic            inRs1Use,
    input  logic            inRs2Use,
    input  logic [4:0]      inRdAddr,
    input  logic            inRdWrite,
    output logic [4:0]      rfRs1Addr,
    output logic [4:0]      rfRs2Addr,
    input  logic [XLEN-1:0] rfRs1Data,
    input  logic [XLEN-1:0] rfRs2Data,
    input  logic            exValid,
    input  logic [4:0]      exRdAddr,
    input  logic            exDataReady,
    input  logic [XLEN-1:0] exData,
    input  logic            memValid,
    input  logic [4:0]      memRdAddr,
    input  logic            memDataReady,
    input  logic [XLEN-1:0] memData,
    input  logic            wbEnable,
    input  logic [4:0]      wbRdAddr,
    input  logic [XLEN-1:0] wbData,
    input  logic            retireValid,
    input  logic            retireRdWrite,
    input  logic [4:0]      retireRdAddr,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outRs1Data,
    output logic [XLEN-1:0] outRs2Data,
    output logic [4:0]      outRdAddr,
    output logic            outRdWrite
);

    BypassPort ex_port, mem_port, wb_port;
    Operand    op1, op2;
    logic      rs1_busy, rs2_busy, rd_full;
    logic      held_writes, held_blocks1, held_blocks2, overflow;
    logic      hazard, issue, accept, inc, dec;

    assign rfRs1Addr = inRs1Addr;
    assign rfRs2Addr = inRs2Addr;

    assign ex_port  = '{valid: exValid,  rdAddr: exRdAddr,  dataReady: exDataReady,  data: exData};
    assign mem_port = '{valid: memValid, rdAddr: memRdAddr, dataReady: memDataReady, data: memData};
    assign wb_port  = '{valid: wbEnable, rdAddr: wbRdAddr,  dataReady: 1'b1,         data: wbData};

    assign op1 = resolve_operand(inRs1Use, inRs1Addr, rfRs1Data, rs1_busy, ex_port, mem_port, wb_port);
    assign op2 = resolve_operand(inRs2Use, inRs2Addr, rfRs2Data, rs2_busy, ex_port, mem_port, wb_port);

    // The held instruction's result has no bypass path yet, so readers of its rd must wait.
    assign held_writes  = outValid && outRdWrite;
    assign held_blocks1 = inRs1Use && inRs1Addr != ZERO_REG && held_writes && outRdAddr == inRs1Addr;
    assign held_blocks2 = inRs2Use && inRs2Addr != ZERO_REG && held_writes && outRdAddr == inRs2Addr;
    assign overflow     = inRdWrite && inRdAddr != ZERO_REG && rd_full;

    assign hazard  = !op1.ready || !op2.ready || held_blocks1 || held_blocks2 || overflow;
    assign issue   = outValid && outReady;
    assign inReady = (!outValid || outReady) && !hazard && !flush;
    assign accept  = inValid && inReady;

    assign inc = issue && !flush && outRdWrite && outRdAddr != ZERO_REG;
    assign dec = retireValid && retireRdWrite && retireRdAddr != ZERO_REG;

    scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .inc_addr   (outRdAddr),
        .dec        (dec),
        .dec_addr   (retireRdAddr),
        .rs1_addr   (inRs1Addr),
        .rs2_addr   (inRs2Addr),
        .rd_addr    (inRdAddr),
        .rd_pending (held_writes && outRdAddr == inRdAddr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_full    (rd_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid   <= 1'b0;
            outRs1Data <= '0;
            outRs2Data <= '0;
            outRdAddr  <= '0;
            outRdWrite <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid   <= 1'b1;
            outRs1Data <= op1.value;
            outRs2Data <= op2.value;
            outRdAddr  <= inRdAddr;
            outRdWrite <= inRdWrite;
        end else if (issue) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios, then random traffic
// checked against an in-flight-list reference model.
module tb_operand_fetch;

    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst, inValid, inReady, inRs1Use, inRs2Use, inRdWrite;
    logic [4:0]  inRs1Addr, inRs2Addr, inRdAddr, rfRs1Addr, rfRs2Addr;
    logic [31:0] rfRs1Data, rfRs2Data;
    logic        exValid, exDataReady, memValid, memDataReady, wbEnable;
    logic [4:0]  exRdAddr, memRdAddr, wbRdAddr;
    logic [31:0] exData, memData, wbData;
    logic        retireValid, retireRdWrite, flush, outValid, outReady, outRdWrite;
    logic [4:0]  retireRdAddr, outRdAddr;
    logic [31:0] outRs1Data, outRs2Data;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr), .inRs1Use(inRs1Use), .inRs2Use(inRs2Use),
        .inRdAddr(inRdAddr), .inRdWrite(inRdWrite),
        .rfRs1Addr(rfRs1Addr), .rfRs2Addr(rfRs2Addr), .rfRs1Data(rfRs1Data), .rfRs2Data(rfRs2Data),
        .exValid(exValid), .exRdAddr(exRdAddr), .exDataReady(exDataReady), .exData(exData),
        .memValid(memValid), .memRdAddr(memRdAddr), .memDataReady(memDataReady), .memData(memData),
        .wbEnable(wbEnable), .wbRdAddr(wbRdAddr), .wbData(wbData),
        .retireValid(retireValid), .retireRdWrite(retireRdWrite), .retireRdAddr(retireRdAddr),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .outRs1Data(outRs1Data), .outRs2Data(outRs2Data), .outRdAddr(outRdAddr), .outRdWrite(outRdWrite)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic [4:0] rd;
    } flight_t;

    // Issued instructions not yet retired, oldest first; their writers are what the counters hold.
    flight_t     flight[$];
    logic        mValid = 1'b0;
    logic        mWr    = 1'b0;
    logic [4:0]  mRd    = '0;
    logic [31:0] mD1    = '0;
    logic [31:0] mD2    = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int inflight(input logic [4:0] r);
        int n = 0;
        foreach (flight[i]) if (flight[i].wr && flight[i].rd == r) n++;
        return n;
    endfunction

    function automatic void resolve(input logic used, input logic [4:0] a, input logic [31:0] rf,
                                    output logic ok, output logic [31:0] v);
        ok = 1'b1;
        v  = '0;
        if (!used || a == 5'd0) return;
        if (mValid && mWr && mRd == a) begin
            ok = 1'b0;
            return;
        end
        if (exValid && exRdAddr == a) begin
            ok = exDataReady;
            v  = exData;
        end else if (memValid && memRdAddr == a) begin
            ok = memDataReady;
            v  = memData;
        end else if (wbEnable && wbRdAddr == a) begin
            v = wbData;
        end else if (inflight(a) == 0) begin
            v = rf;
        end else begin
            ok = 1'b0;
        end
    endfunction

    task automatic setIdle();
        rst = 0; inValid = 0; flush = 0; outReady = 1;
        inRs1Addr = 0; inRs2Addr = 0; inRs1Use = 0; inRs2Use = 0; inRdAddr = 0; inRdWrite = 0;
        rfRs1Data = 0; rfRs2Data = 0;
        exValid = 0; exRdAddr = 0; exDataReady = 0; exData = 0;
        memValid = 0; memRdAddr = 0; memDataReady = 0; memData = 0;
        wbEnable = 0; wbRdAddr = 0; wbData = 0;
        retireValid = 0; retireRdWrite = 0; retireRdAddr = 0;
    endtask

    task automatic setInstr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic wr);
        inRs1Addr = rs1; inRs1Use = u1; inRs2Addr = rs2; inRs2Use = u2; inRdAddr = rd; inRdWrite = wr;
    endtask

    task automatic expectReady(input string tag, input logic exp);
        #1;
        checkOutput(tag, 32'(inReady), 32'(exp));
    endtask

    // One clock: check combinational outputs against the model, advance the model at the edge, check registers.
    task automatic applyStimulus();
        logic        ok1, ok2, ovf, expReady, acc, iss;
        logic [31:0] v1, v2;
        int          pend;
        flight_t     e;
        #1;
        resolve(inRs1Use, inRs1Addr, rfRs1Data, ok1, v1);
        resolve(inRs2Use, inRs2Addr, rfRs2Data, ok2, v2);
        pend = inflight(inRdAddr) + ((mValid && mWr && mRd == inRdAddr) ? 1 : 0);
        ovf = inRdWrite && inRdAddr != 5'd0 && pend >= CNT_MAX;
        expReady = (!mValid || outReady) && ok1 && ok2 && !ovf && !flush;
        if (!rst) checkOutput("inReady", 32'(inReady), 32'(expReady));
        checkOutput("rfRs1Addr", 32'(rfRs1Addr), 32'(inRs1Addr));
        checkOutput("rfRs2Addr", 32'(rfRs2Addr), 32'(inRs2Addr));
        acc = inValid && expReady;
        iss = mValid && outReady;
        @(posedge clk);
        if (rst) begin
            mValid = 0; mWr = 0; mRd = 0; mD1 = 0; mD2 = 0;
            flight.delete();
        end else begin
            if (retireValid) flight.delete(0);
            if (iss && !flush) begin
                e.wr = mWr;
                e.rd = mRd;
                flight.push_back(e);
            end
            if (flush) mValid = 0;
            else if (acc) begin
                mValid = 1; mD1 = v1; mD2 = v2; mRd = inRdAddr; mWr = inRdWrite;
            end else if (iss) mValid = 0;
        end
        #1;
        checkOutput("outValid", 32'(outValid), 32'(mValid));
        if (mValid || rst) begin
            checkOutput("outRs1Data", outRs1Data, mD1);
            checkOutput("outRs2Data", outRs2Data, mD2);
            checkOutput("outRdAddr", 32'(outRdAddr), 32'(mRd));
            checkOutput("outRdWrite", 32'(outRdWrite), 32'(mWr));
        end
    endtask

    initial begin
        setIdle();
        rst = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_outValid", 32'(outValid), 32'd0);
        checkOutput("reset_outRs1Data", outRs1Data, 32'd0);
        checkOutput("reset_outRdAddr", 32'(outRdAddr), 32'd0);

        @(negedge clk); setIdle();
        setInstr(5, 1, 5, 1, 6, 1); inValid = 1; rfRs1Data = 32'h1234; rfRs2Data = 32'h1234;
        expectReady("nohaz_inReady", 1'b1);
        applyStimulus();
        checkOutput("nohaz_outValid", 32'(outValid), 32'd1);
        checkOutput("nohaz_rs1", outRs1Data, 32'h1234);
        checkOutput("nohaz_rs2", outRs2Data, 32'h1234);

        @(negedge clk); setIdle();
        expectReady("nohaz_inReady_stays", 1'b1);
        applyStimulus();

        @(negedge clk); setIdle();
        setInstr(6, 1, 0, 0, 9, 1); inValid = 1; rfRs1Data = 32'h777;
        exValid = 1; exRdAddr = 6; exDataReady = 1; exData = 32'hAA;
        expectReady("exbyp_inReady", 1'b1);
        applyStimulus();
        checkOutput("exbyp_rs1", outRs1Data, 32'hAA);

        @(negedge clk); setIdle();
        setInstr(6, 1, 0, 0, 10, 1); inValid = 1; rfRs1Data = 32'h777;
        exValid = 1; exRdAddr = 6; exDataReady = 0; exData = 32'h0;
        expectReady("loaduse_stall", 1'b0);
        applyStimulus();
        checkOutput("loaduse_outValid", 32'(outValid), 32'd0);

        @(negedge clk); setIdle();
        setInstr(6, 1, 0, 0, 10, 1); inValid = 1; rfRs1Data = 32'h777;
        memValid = 1; memRdAddr = 6; memDataReady = 1; memData = 32'h55;
        expectReady("loaduse_resume", 1'b1);
        applyStimulus();
        checkOutput("loaduse_rs1", outRs1Data, 32'h55);

        @(negedge clk); setIdle();
        setInstr(7, 1, 0, 0, 11, 1); inValid = 1; rfRs1Data = 32'h11;
        wbEnable = 1; wbRdAddr = 7; wbData = 32'h99;
        applyStimulus();
        checkOutput("wb_rs1", outRs1Data, 32'h99);

        @(negedge clk); setIdle();
        setInstr(0, 0, 0, 0, 8, 1); inValid = 1;
        applyStimulus();
        checkOutput("flush_setup_rd", 32'(outRdAddr), 32'd8);
        @(negedge clk); setIdle();
        setInstr(0, 0, 0, 0, 12, 1); inValid = 1; flush = 1;
        expectReady("flush_blocks_accept", 1'b0);
        applyStimulus();
        checkOutput("flush_outValid", 32'(outValid), 32'd0);
        @(negedge clk); setIdle();
        setInstr(8, 1, 0, 0, 13, 0); inValid = 1; rfRs1Data = 32'h88;
        expectReady("flush_no_count", 1'b1);
        applyStimulus();
        checkOutput("flush_reader_rs1", outRs1Data, 32'h88);

        @(negedge clk); setIdle();
        setInstr(0, 1, 0, 1, 0, 1); inValid = 1; rfRs1Data = 32'hDEAD; rfRs2Data = 32'hDEAD;
        exValid = 1; exRdAddr = 0; exDataReady = 1; exData = 32'hFF;
        applyStimulus();
        checkOutput("x0_rs1", outRs1Data, 32'd0);
        checkOutput("x0_rs2", outRs2Data, 32'd0);

        @(negedge clk); setIdle();
        setInstr(5, 1, 0, 0, 14, 1); inValid = 1; rfRs1Data = 32'hBEEF;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); setIdle();
            outReady = 0; inValid = 1; setInstr(1, 1, 2, 1, 15, 1);
            rfRs1Data = $urandom; rfRs2Data = $urandom;
            expectReady("bp_inReady", 1'b0);
            applyStimulus();
            checkOutput("bp_outValid", 32'(outValid), 32'd1);
            checkOutput("bp_rs1_stable", outRs1Data, 32'hBEEF);
            checkOutput("bp_rd_stable", 32'(outRdAddr), 32'd14);
        end

        @(negedge clk); setIdle();
        rst = 1; inValid = 1; outReady = 0; setInstr(3, 1, 4, 1, 16, 1);
        applyStimulus();
        checkOutput("midreset_outValid", 32'(outValid), 32'd0);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk); setIdle();
            inValid   = ($urandom_range(0, 9) < 7);
            setInstr(5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            rfRs1Data = $urandom; rfRs2Data = $urandom;
            exValid   = ($urandom_range(0, 3) == 0); exRdAddr = 5'($urandom_range(0, 7));
            exDataReady = ($urandom_range(0, 1) == 1); exData = $urandom;
            memValid  = ($urandom_range(0, 3) == 0); memRdAddr = 5'($urandom_range(0, 7));
            memDataReady = ($urandom_range(0, 1) == 1); memData = $urandom;
            wbEnable  = ($urandom_range(0, 3) == 0); wbRdAddr = 5'($urandom_range(0, 7)); wbData = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            outReady  = ($urandom_range(0, 9) < 7);
            retireValid = (flight.size() > 0) && ($urandom_range(0, 1) == 1);
            if (retireValid) begin
                retireRdWrite = flight[0].wr;
                retireRdAddr  = flight[0].rd;
            end
            applyStimulus();
        end

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
